// File: rtl/decode_stage_pkg.sv
// Shared types and opcode prefixes for the 9-bit ISA decode stage.
package decode_stage_pkg;

   localparam int unsigned RAW_W = 4;

   localparam logic [4:0] OP_LOAD   = 5'b11010;
   localparam logic [4:0] OP_STORE  = 5'b11011;
   localparam logic [3:0] OP_LFSR   = 4'b0010;
   localparam logic [3:0] OP_RCXFER = 4'b0100;
   localparam logic [3:0] OP_PARITY = 4'b0101;
   localparam logic [3:0] OP_COPY   = 4'b0110;
   localparam logic [3:0] OP_BRANCH = 4'b1111;

   typedef enum logic [1:0] {RUN, STALL, HALT} decode_state_t;

   typedef struct packed {
      logic             cond_jump;
      logic             br_abs_rel;
      logic             reg_wr_en;
      logic             mem_wr_en;
      logic             load_inst;
      logic             mid_flag1;
      logic             mid_flag2;
      logic [2:0]       const_ctrl;
      logic [1:0]       br_cond;
      logic [RAW_W-1:0] addr_a;
      logic [RAW_W-1:0] addr_b;
      logic [RAW_W-1:0] addr_w;
   } ctrl_bundle_t;

endpackage

// File: rtl/decode_stage_decode_logic.sv
// Pure combinational decode of one instruction into the control bundle.
module decode_logic
   import decode_stage_pkg::*;
#(
   parameter int unsigned IW      = 9,
   parameter int unsigned RC_IDX  = 15,
   parameter int unsigned BR_BASE = 11
) (
   input  logic [IW-1:0] instr,
   output ctrl_bundle_t  ctrl
);

   logic [4:0]       op5;
   logic [3:0]       op4;
   logic [RAW_W-1:0] rc;
   logic [RAW_W-1:0] low4;

   assign op5  = instr[IW-1 -: 5];
   assign op4  = instr[IW-1 -: 4];
   assign rc   = RAW_W'(RC_IDX);
   assign low4 = RAW_W'(instr[3:0]);

   always_comb begin
      ctrl            = '0;
      ctrl.mem_wr_en  = (op5 == OP_STORE);
      ctrl.load_inst  = (op5 == OP_LOAD);
      ctrl.reg_wr_en  = !((op5[4:2] == 3'b111) || (op5 == OP_STORE) || (op5 == {OP_LFSR, 1'b0}));
      ctrl.mid_flag1  = instr[4];
      ctrl.mid_flag2  = instr[5];
      ctrl.const_ctrl = instr[4:2];
      ctrl.br_cond    = instr[3:2];
      ctrl.br_abs_rel = instr[4];
      ctrl.addr_a     = RAW_W'(instr[1:0]);
      ctrl.addr_b     = RAW_W'(instr[3:2]);
      ctrl.addr_w     = RAW_W'(instr[1:0]);

      if (op4[3:2] == 2'b00 && op4[1:0] != 2'b10) begin
         ctrl.addr_w = rc;
         ctrl.addr_a = rc;
      end else begin
         case (op4)
            OP_RCXFER: begin
               if (instr[4]) begin
                  ctrl.addr_b = rc;
                  ctrl.addr_w = low4;
               end else begin
                  ctrl.addr_w = rc;
                  ctrl.addr_b = low4;
               end
            end
            OP_LFSR: begin
               ctrl.addr_a = rc;
               if (instr[4]) begin
                  ctrl.addr_b = low4;
                  ctrl.addr_w = low4;
               end else begin
                  ctrl.addr_b = rc;
               end
            end
            OP_PARITY: begin
               ctrl.addr_a = low4;
               ctrl.addr_b = low4;
               ctrl.addr_w = low4;
            end
            OP_BRANCH: begin
               ctrl.cond_jump = 1'b1;
               ctrl.addr_a    = RAW_W'(instr[1:0]) + RAW_W'(BR_BASE);
            end
            OP_COPY: begin
               if (instr[4]) begin
                  ctrl.addr_a = rc;
                  ctrl.addr_b = low4;
               end
            end
            default: ;
         endcase
      end

      // Ack (all ones) aliases the branch opcode; it must have no side effects.
      if (&instr) begin
         ctrl.cond_jump = 1'b0;
         ctrl.reg_wr_en = 1'b0;
         ctrl.mem_wr_en = 1'b0;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: ID/EX register, handshake, flush, halt on Ack.
// Load-use interlock and StallCnt exist only with DECODE_STAGE_HAZARD_EN.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int unsigned IW      = 9,
   parameter int unsigned RAW     = RAW_W,
   parameter int unsigned RC_IDX  = 15,
   parameter int unsigned BR_BASE = 11,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [IW-1:0]    Instruction,
   input  logic             InstrValid,
   output logic             InstrReady,
   input  logic             Flush,
   input  logic             ExReady,
   output logic             ExValid,
   output logic             ConditionalJump,
   output logic             BranchAbsOrRel,
   output logic             RegWrEn,
   output logic             MemWrEn,
   output logic             LoadInst,
   output logic             MiddleFlag1,
   output logic             MiddleFlag2,
   output logic [2:0]       ConstantControl,
   output logic [1:0]       BranchConditions,
   output logic [RAW-1:0]   RegReadAddrA,
   output logic [RAW-1:0]   RegReadAddrB,
   output logic [RAW-1:0]   RegWriteAddr,
   output logic             Done,
   output logic [CNT_W-1:0] StallCnt
);

   ctrl_bundle_t  dec;
   ctrl_bundle_t  ex_q;
   logic          ex_valid_q;
   decode_state_t state;
   decode_state_t state_next;
   logic          hazard;
   logic          transfer;
   logic          load_ex;
   logic          clear_ex;

   decode_logic #(
      .IW      (IW),
      .RC_IDX  (RC_IDX),
      .BR_BASE (BR_BASE)
   ) u_decode (
      .instr (Instruction),
      .ctrl  (dec)
   );

`ifdef DECODE_STAGE_HAZARD_EN
   logic [CNT_W-1:0] stall_cnt;

   assign hazard = ex_valid_q && ex_q.load_inst && InstrValid &&
                   ((ex_q.addr_w == dec.addr_a) || (ex_q.addr_w == dec.addr_b));

   always_ff @(posedge Clk) begin
      if (Reset)
         stall_cnt <= '0;
      else if (!Flush && hazard && ExReady && !(&stall_cnt))
         stall_cnt <= stall_cnt + 1'b1;
   end

   assign StallCnt = stall_cnt;
`else
   assign hazard   = 1'b0;
   assign StallCnt = '0;
`endif

   assign InstrReady = (state != HALT) && !Flush && !hazard && (!ex_valid_q || ExReady);
   assign transfer   = InstrValid && InstrReady;

   always_comb begin
      state_next = state;
      load_ex    = 1'b0;
      clear_ex   = 1'b0;
      if (Flush) begin
         clear_ex = 1'b1;
         if (state != HALT) state_next = RUN;
      end else if (transfer) begin
         load_ex    = 1'b1;
         state_next = (&Instruction) ? HALT : RUN;
      end else begin
         // A consumed entry with nothing new behind it becomes a bubble.
         clear_ex = ExReady;
         case (state)
            RUN:     if (hazard && ExReady) state_next = STALL;
            STALL:   state_next = RUN;
            default: state_next = state;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= RUN;
         ex_valid_q <= 1'b0;
         ex_q       <= '0;
      end else begin
         state <= state_next;
         if (load_ex) begin
            ex_valid_q <= 1'b1;
            ex_q       <= dec;
         end else if (clear_ex) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
         end
      end
   end

   assign ExValid          = ex_valid_q;
   assign Done             = (state == HALT);
   assign ConditionalJump  = ex_q.cond_jump;
   assign BranchAbsOrRel   = ex_q.br_abs_rel;
   assign RegWrEn          = ex_q.reg_wr_en;
   assign MemWrEn          = ex_q.mem_wr_en;
   assign LoadInst         = ex_q.load_inst;
   assign MiddleFlag1      = ex_q.mid_flag1;
   assign MiddleFlag2      = ex_q.mid_flag2;
   assign ConstantControl  = ex_q.const_ctrl;
   assign BranchConditions = ex_q.br_cond;
   assign RegReadAddrA     = RAW'(ex_q.addr_a);
   assign RegReadAddrB     = RAW'(ex_q.addr_b);
   assign RegWriteAddr     = RAW'(ex_q.addr_w);

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage for the 9-bit ISA processor. It sits between fetch (instruction ROM / program counter) and execute. It decodes one instruction per cycle into the standard control bundle, holds the result in an ID/EX pipeline register, and adds what the purely combinational decoder lacked:

- valid/ready handshaking
- load-use interlock
- branch flush
- sticky halt on the Ack instruction

## Interface

Parameters:
- IW, 9: instruction width; field positions below are for IW=9, and upper opcode bits scale with IW.
- RAW, 4: register address width.
- RC_IDX, 15: index of RC register.
- BR_BASE, 11: base register index for branch-condition operand.
- CNT_W, 8: stall counter width.

Ports:
- Clk in 1: clock; single clock domain.
- Reset in 1: synchronous, active-high reset.
- Instruction in IW: machine code from fetch.
- InstrValid in 1: Instruction is meaningful this cycle.
- InstrReady out 1: decode accepts Instruction this cycle.
- Flush in 1: taken branch resolved downstream; squash.
- ExReady in 1: execute accepts ID/EX contents.
- ExValid out 1: ID/EX register holds a live instruction.
- ConditionalJump, BranchAbsOrRel, RegWrEn, MemWrEn, LoadInst, MiddleFlag1, MiddleFlag2 out 1 each: registered controls.
- ConstantControl out 3; BranchConditions out 2.
- RegReadAddrA, RegReadAddrB, RegWriteAddr out RAW each.
- Done out 1: sticky halt flag.
- StallCnt out CNT_W: saturating count of interlock bubbles.

## Operation

Decode rules (combinational, i = Instruction):
- MemWrEn: i[8:4]==11011.
- LoadInst: i[8:4]==11010.
- RegWrEn: true unless i[8:6]==111, i[8:4]==11011 or i[8:4]==00100.
- Default addresses: A=i[1:0], B=i[3:2], W=i[1:0]; MiddleFlag1=i[4]; MiddleFlag2=i[5]; ConstantControl=i[4:2]; BranchConditions=i[3:2]; BranchAbsOrRel=i[4].
- i[8:7]==00, i[6:5]!=10: W=A=RC_IDX.
- i[8:5]==0100, i[4]=0: W=RC_IDX, B=i[3:0].
- i[8:5]==0100, i[4]=1: B=RC_IDX, W=i[3:0].
- i[8:5]==0010, i[4]=0: A=B=RC_IDX.
- i[8:5]==0010, i[4]=1: A=RC_IDX, B=W=i[3:0].
- i[8:5]==0101: A=B=W=i[3:0].
- i[8:5]==1111: ConditionalJump=1; A=i[1:0]+BR_BASE.
- i[8:5]==0110, i[4]=0: W=i[1:0], B=i[3:2].
- i[8:5]==0110, i[4]=1: A=RC_IDX, B=i[3:0].
- Ack = all-ones instruction. It decodes with ConditionalJump, RegWrEn and MemWrEn forced 0.

Handshake:
- Transfer occurs when InstrValid && InstrReady.
- InstrReady = !Done && !Flush && !hazard && (!ExValid || ExReady).
- ExValid && !ExReady: all ID/EX outputs hold stable.

FSM states:
- RUN: normal operation.
- STALL: one bubble inserted. Always returns to RUN next cycle.
- HALT: entered the cycle after an Ack transfer. InstrReady=0 and Done=1 until Reset. The registered Ack still presents ExValid=1 until consumed.

Hazard condition: ExValid && LoadInst && InstrValid, and RegWriteAddr equals the decoded A or B of Instruction.
- Effect: no transfer. If ExReady, ExValid goes 0 next cycle (bubble), state goes STALL, and StallCnt increments, saturating at all-ones.

Flush:
- Next cycle ExValid=0.
- Any instruction presented that cycle is not accepted.
- Flush has priority over hazard and transfer. No STALL is entered and StallCnt is unchanged.

Reset clears ExValid, Done and StallCnt, zeroes all control/address outputs, and sets state RUN. This holds mid-stall and in HALT.

## Timing

- Latency: 1 cycle from accepted Instruction to registered controls.
- Throughput: 1 instruction/cycle without hazards.
- Load-use costs exactly 1 bubble cycle.
- InstrReady is combinational from Flush, ExReady and Instruction.
- Outputs are registered only. Bubble cycles show ExValid=0 with controls zeroed.

## Configuration

DECODE_STAGE_HAZARD_EN:
- Defined: load-use interlock, STALL state and StallCnt active.
- Undefined: hazard is constant 0, StallCnt is tied 0, no STALL state. Software must schedule a gap after each load.

## Structure

- Package definitions gains: opcode prefix constants (OP_LOAD=11010, OP_STORE=11011, OP_LFSR=0010, OP_RCXFER=0100, OP_PARITY=0101, OP_COPY=0110, OP_BRANCH=1111), state enum decode_state_t {RUN, STALL, HALT}, and struct ctrl_bundle_t holding all control/address fields.
- Sub-module decode_logic: pure combinational decode of Instruction into ctrl_bundle_t. decode_stage adds the registers, FSM and counter.

## Test plan

- Reset asserted mid-STALL: next cycle ExValid=0, Done=0, StallCnt=0, all address outputs 0.
- 9'b000000011 (RC add), ExReady=1: next cycle RegWriteAddr=15, RegReadAddrA=15, RegReadAddrB=0, RegWrEn=1, ExValid=1.
- 9'b110100001 (load R1) then 9'b100000100 (B=R1): one cycle ExValid=0, StallCnt=1, second instruction registered a cycle later. Without macro: no bubble.
- 9'b111100010 followed by Flush=1: ConditionalJump=1, RegReadAddrA=13; the cycle after Flush ExValid=0 and following instruction not accepted.
- 9'b111111111: ExValid=1 with ConditionalJump=0, RegWrEn=0; then Done=1, InstrReady=0 permanently until Reset.
- ExReady=0 for 3 cycles with 9'b110110010 registered: MemWrEn=1 held, InstrReady=0, outputs unchanged throughout.
